uart_rx_deserializer: RTL and testbench
=======================================

# uart_rx_deserializer

Receive-path stage directly downstream of the UART start-bit frame detector. On the detector's one-cycle `start_detected` pulse, it samples `DATA_BITS` data bits LSB-first at bit centres using the 16x baud tick. It then checks the stop bit and presents the assembled word with a valid or error strobe. Its `rx_done` pulse is returned to the frame detector to release it back to idle hunting.

## Interface
- `DATA_BITS`, default 8 — data bits per frame, legal range 5..8.
- `PARITY_ODD`, default 0 — parity sense when parity is compiled in: 0 = even, 1 = odd. Ignored otherwise.
- `clk` in 1 — system clock.
- `reset` in 1 — synchronous, active-high.
- `baud_in_pos_edge` in 1 — single-cycle tick at 16x the baud rate.
- `rx_data` in 1 — synchronised serial input line, idle high.
- `start_detected` in 1 — one-cycle pulse from the frame detector, aligned to the centre of data bit 0.
- `rx_byte` out `DATA_BITS` — last received word, LSB = first bit on the line.
- `rx_valid` out 1 — one-cycle pulse: `rx_byte` updated, frame good.
- `framing_error` out 1 — one-cycle pulse: stop bit sampled low.
- `parity_error` out 1 — one-cycle pulse: parity mismatch. Constant 0 when parity is not compiled in.
- `rx_done` out 1 — one-cycle pulse at the end of every frame, good or bad.
- `busy` out 1 — high in every state except IDLE.

## Operation
- States: IDLE, DATA, PARITY (present only with the macro), STOP, DONE.
- Counters:
  - tick counter, 4-bit;
  - bit counter, width `$clog2(DATA_BITS)`;
  - shift register, `DATA_BITS` wide, shifts right with the new bit entering at the MSB.
- IDLE → DATA on `start_detected`:
  - `rx_data` is sampled in that same cycle as bit 0;
  - tick counter cleared to 0;
  - bit counter set to 1.
- Sample rule in DATA, PARITY and STOP: on each `baud_in_pos_edge` the tick counter increments. When it is 15 and a tick arrives, the line is sampled and the counter wraps to 0. Every sample is therefore exactly 16 ticks after the previous one.
- DATA:
  - each sample shifts in one bit;
  - after the sample that completes `DATA_BITS` bits, go to PARITY (macro defined) or STOP.
- PARITY: one sample is taken, then go to STOP.
- STOP: one sample is taken, then go to DONE.
  - Sample = 1: `rx_byte` loads the shift register.
  - Sample = 0: flag a framing error. `rx_byte` keeps its old value.
- DONE, one cycle:
  - `rx_done` = 1;
  - either `rx_valid` = 1, or `framing_error` = 1;
  - `parity_error` = 1 if parity mismatched;
  - next state IDLE.
- Error precedence: a parity error still loads `rx_byte` and asserts `rx_valid` if the stop bit was good. Firmware qualifies the word with `parity_error`. `framing_error` and `rx_valid` are never high together.
- `start_detected` outside IDLE is ignored.
- `start_detected` coinciding with `baud_in_pos_edge` in IDLE: the start is taken and that tick is not counted.
- `baud_in_pos_edge` in IDLE or DONE is ignored.

## Timing
- Reset values: `rx_byte` = 0; `rx_valid`, `framing_error`, `parity_error`, `rx_done`, `busy` = 0; state IDLE; all counters 0.
- Reset mid-frame: back to IDLE on the next edge; no `rx_done` or any strobe is emitted.
- All outputs are registered.
- `busy` rises the cycle after `start_detected` and falls the cycle after DONE.
- Latency from `start_detected` to `rx_done`, in `baud_in_pos_edge` ticks plus 1 clk:
  - 16 × `DATA_BITS` ticks without parity (8N1: 128 ticks);
  - 16 × (`DATA_BITS` + 1) ticks with parity.
- Back-to-back frames: the detector's next `start_detected` can arrive no earlier than the cycle after DONE. It is accepted in IDLE with no dead cycle.

## Configuration
- `UART_RX_PARITY_EN`:
  - Defined: the PARITY state exists. One extra bit is sampled between data and stop. Expected parity is the XOR of the data bits, inverted when `PARITY_ODD` = 1. A mismatch pulses `parity_error` in DONE.
  - Undefined: no PARITY state, the stop bit immediately follows the last data bit, and `parity_error` is tied to 0.

## Test plan
- 8N1, byte 0xA5 LSB-first, 16 ticks per bit, good stop → `rx_byte` = 0xA5, `rx_valid` and `rx_done` each pulse 1 cycle, `framing_error` = 0, `busy` low afterwards.
- Byte 0x3C with stop bit driven 0 → `framing_error` and `rx_done` pulse, `rx_valid` stays 0, `rx_byte` keeps the previous 0xA5.
- Reset asserted after 3 data bits of 0xFF → all outputs 0 next cycle, no `rx_done`; a following frame 0x81 is received correctly.
- Extra `start_detected` pulses at ticks 20 and 60 of a 0x55 frame → ignored; 0x55 received with normal 128-tick latency.
- Two frames 0x00 and 0xFF with the second `start_detected` the cycle after the first `rx_done` → both `rx_valid` pulses, correct values.
- `UART_RX_PARITY_EN`, `PARITY_ODD` = 0: 0x07 with parity bit 1 → `rx_valid` only; with parity bit 0 → `rx_valid` and `parity_error` both pulse.

Source files
------------

// File: rtl/uart_rx_deserializer.sv
// rtl/uart_rx_deserializer.sv - UART receive deserializer: data/stop sampling at bit centres, optional parity (UART_RX_PARITY_EN)
module uart_rx_deserializer #(
  parameter int DATA_BITS  = 8,
  parameter int PARITY_ODD = 0
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 baud_in_pos_edge,
  input  logic                 rx_data,
  input  logic                 start_detected,
  output logic [DATA_BITS-1:0] rx_byte,
  output logic                 rx_valid,
  output logic                 framing_error,
  output logic                 parity_error,
  output logic                 rx_done,
  output logic                 busy
);

  localparam int BCW = $clog2(DATA_BITS);
  localparam logic [BCW-1:0] LAST_BIT = BCW'(DATA_BITS - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    DATA   = 3'd1,
`ifdef UART_RX_PARITY_EN
    PARITY = 3'd2,
`endif
    STOP   = 3'd3,
    DONE   = 3'd4
  } state_t;

  state_t               state;
  logic [3:0]           tick_cnt;
  logic [BCW-1:0]       bit_cnt;
  logic [DATA_BITS-1:0] shift_reg;

  // The line is sampled on the tick that wraps the 16-tick counter, i.e. one bit period after the previous sample.
  logic sample_now;
  assign sample_now = baud_in_pos_edge && (tick_cnt == 4'hF);

`ifdef UART_RX_PARITY_EN
  localparam logic ODD_SENSE = (PARITY_ODD != 0);
  logic parity_bit;
`else
  logic unused_parity_odd;
  assign unused_parity_odd = (PARITY_ODD != 0);
  assign parity_error = 1'b0;
`endif

  // Frame FSM: counters, shift register and all registered strobes.
  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      tick_cnt      <= 4'd0;
      bit_cnt       <= '0;
      shift_reg     <= '0;
      rx_byte       <= '0;
      rx_valid      <= 1'b0;
      framing_error <= 1'b0;
      rx_done       <= 1'b0;
      busy          <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_bit    <= 1'b0;
      parity_error  <= 1'b0;
`endif
    end else begin
      // Strobes are one-cycle pulses unless re-asserted below.
      rx_valid      <= 1'b0;
      framing_error <= 1'b0;
      rx_done       <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_error  <= 1'b0;
`endif
      case (state)
        IDLE: begin
          // The start pulse is aligned to the centre of bit 0, so bit 0 is taken right away.
          if (start_detected) begin
            shift_reg <= {rx_data, shift_reg[DATA_BITS-1:1]};
            tick_cnt  <= 4'd0;
            bit_cnt   <= BCW'(1);
            busy      <= 1'b1;
            state     <= DATA;
          end
        end
        DATA: begin
          if (baud_in_pos_edge) begin
            tick_cnt <= tick_cnt + 4'd1;
          end
          if (sample_now) begin
            shift_reg <= {rx_data, shift_reg[DATA_BITS-1:1]};
            if (bit_cnt == LAST_BIT) begin
              bit_cnt <= '0;
`ifdef UART_RX_PARITY_EN
              state   <= PARITY;
`else
              state   <= STOP;
`endif
            end else begin
              bit_cnt <= bit_cnt + BCW'(1);
            end
          end
        end
`ifdef UART_RX_PARITY_EN
        PARITY: begin
          if (baud_in_pos_edge) begin
            tick_cnt <= tick_cnt + 4'd1;
          end
          if (sample_now) begin
            parity_bit <= rx_data;
            state      <= STOP;
          end
        end
`endif
        STOP: begin
          if (baud_in_pos_edge) begin
            tick_cnt <= tick_cnt + 4'd1;
          end
          if (sample_now) begin
            // A bad stop bit leaves the previously delivered word untouched.
            if (rx_data) begin
              rx_byte  <= shift_reg;
              rx_valid <= 1'b1;
            end else begin
              framing_error <= 1'b1;
            end
`ifdef UART_RX_PARITY_EN
            parity_error <= parity_bit ^ (^shift_reg) ^ ODD_SENSE;
`endif
            rx_done <= 1'b1;
            state   <= DONE;
          end
        end
        DONE: begin
          tick_cnt <= 4'd0;
          busy     <= 1'b0;
          state    <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx_deserializer.sv
// tb/tb_uart_rx_deserializer.sv - table-driven bench for uart_rx_deserializer
module tb_uart_rx_deserializer;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       baud_in_pos_edge = 1'b0;
  logic       rx_data = 1'b1;
  logic       start_detected = 1'b0;
  logic [7:0] rx_byte;
  logic       rx_valid;
  logic       framing_error;
  logic       parity_error;
  logic       rx_done;
  logic       busy;

  uart_rx_deserializer #(.DATA_BITS(8), .PARITY_ODD(0)) dut (
    .clk              (clk),
    .reset            (reset),
    .baud_in_pos_edge (baud_in_pos_edge),
    .rx_data          (rx_data),
    .start_detected   (start_detected),
    .rx_byte          (rx_byte),
    .rx_valid         (rx_valid),
    .framing_error    (framing_error),
    .parity_error     (parity_error),
    .rx_done          (rx_done),
    .busy             (busy)
  );

  always #5 clk = ~clk;

`ifdef UART_RX_PARITY_EN
  localparam int EXP_LAT = 144;
`else
  localparam int EXP_LAT = 128;
`endif

  typedef struct {
    string      name;
    logic [7:0] data;
    logic       stop_bit;
    logic       par_bit;
    logic [7:0] exp_byte;
    int         exp_valid;
    int         exp_ferr;
    int         exp_perr;
  } vec_t;

  vec_t vecs[$];

  int total = 0;
  int bad = 0;

  int tb_ticks = 0;
  int valid_cnt = 0;
  int done_cnt = 0;
  int ferr_cnt = 0;
  int perr_cnt = 0;
  int both_cnt = 0;
  int done_ticks = -1;
  int got[$];

  // Pulse monitor, sampled on the falling edge away from DUT updates.
  always @(negedge clk) begin
    if (rx_valid) begin
      valid_cnt++;
      got.push_back(int'(rx_byte));
    end
    if (rx_done) begin
      done_cnt++;
      done_ticks = tb_ticks;
    end
    if (framing_error) ferr_cnt++;
    if (parity_error) perr_cnt++;
    if (rx_valid && framing_error) both_cnt++;
  end

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  task automatic clear_counts();
    valid_cnt = 0;
    done_cnt = 0;
    ferr_cnt = 0;
    perr_cnt = 0;
    both_cnt = 0;
    done_ticks = -1;
    got.delete();
  endtask

  // n baud ticks, one clock high then one clock low; optional stray starts at given tick numbers.
  task automatic run_ticks(input int n, input int x1, input int x2);
    for (int k = 0; k < n; k++) begin
      baud_in_pos_edge = 1'b1;
      tb_ticks++;
      if (tb_ticks == x1 || tb_ticks == x2) start_detected = 1'b1;
      @(negedge clk);
      baud_in_pos_edge = 1'b0;
      start_detected = 1'b0;
      @(negedge clk);
    end
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop_bit, input logic par_bit,
                            input int x1, input int x2);
    logic [7:0] dv;
    dv = d;
    rx_data = dv[0];
    start_detected = 1'b1;
    tb_ticks = 0;
    @(negedge clk);
    start_detected = 1'b0;
    for (int b = 1; b < 8; b++) begin
      rx_data = dv[b];
      run_ticks(16, x1, x2);
    end
`ifdef UART_RX_PARITY_EN
    rx_data = par_bit;
    run_ticks(16, x1, x2);
`else
    if (par_bit) rx_data = 1'b1;
`endif
    rx_data = stop_bit;
    run_ticks(16, x1, x2);
    rx_data = 1'b1;
  endtask

  initial begin
    // name, data, stop, parity bit (even), expected byte, valid, ferr, perr
    vecs.push_back('{"a5_good",   8'hA5, 1'b1, 1'b0, 8'hA5, 1, 0, 0});
    vecs.push_back('{"3c_badstop", 8'h3C, 1'b0, 1'b0, 8'hA5, 0, 1, 0});
    vecs.push_back('{"5a_good",   8'h5A, 1'b1, 1'b0, 8'h5A, 1, 0, 0});
    vecs.push_back('{"01_good",   8'h01, 1'b1, 1'b1, 8'h01, 1, 0, 0});
`ifdef UART_RX_PARITY_EN
    vecs.push_back('{"07_par_ok",  8'h07, 1'b1, 1'b1, 8'h07, 1, 0, 0});
    vecs.push_back('{"07_par_bad", 8'h07, 1'b1, 1'b0, 8'h07, 1, 0, 1});
`endif

    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("reset_rx_byte", int'(rx_byte), 0);
    chk("reset_rx_valid", int'(rx_valid), 0);
    chk("reset_framing_error", int'(framing_error), 0);
    chk("reset_parity_error", int'(parity_error), 0);
    chk("reset_rx_done", int'(rx_done), 0);
    chk("reset_busy", int'(busy), 0);

    // Ticks while idle must not start anything.
    clear_counts();
    run_ticks(40, -1, -1);
    chk("idle_ticks_busy", int'(busy), 0);
    chk("idle_ticks_done", done_cnt, 0);

    foreach (vecs[i]) begin
      clear_counts();
      send_frame(vecs[i].data, vecs[i].stop_bit, vecs[i].par_bit, -1, -1);
      repeat (3) @(negedge clk);
      chk({vecs[i].name, "_byte"}, int'(rx_byte), int'(vecs[i].exp_byte));
      chk({vecs[i].name, "_valid"}, valid_cnt, vecs[i].exp_valid);
      chk({vecs[i].name, "_done"}, done_cnt, 1);
      chk({vecs[i].name, "_ferr"}, ferr_cnt, vecs[i].exp_ferr);
      chk({vecs[i].name, "_perr"}, perr_cnt, vecs[i].exp_perr);
      chk({vecs[i].name, "_latency"}, done_ticks, EXP_LAT);
      chk({vecs[i].name, "_busy_after"}, int'(busy), 0);
      chk({vecs[i].name, "_valid_and_ferr"}, both_cnt, 0);
    end

    // Reset after three data bits of 0xFF: everything clears, no frame end is reported.
    clear_counts();
    rx_data = 1'b1;
    start_detected = 1'b1;
    tb_ticks = 0;
    @(negedge clk);
    start_detected = 1'b0;
    run_ticks(40, -1, -1);
    chk("midframe_busy", int'(busy), 1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("abort_rx_byte", int'(rx_byte), 0);
    chk("abort_busy", int'(busy), 0);
    chk("abort_strobes", int'({rx_valid, framing_error, parity_error, rx_done}), 0);
    run_ticks(160, -1, -1);
    chk("abort_no_done", done_cnt, 0);
    chk("abort_busy_later", int'(busy), 0);
    clear_counts();
    send_frame(8'h81, 1'b1, 1'b0, -1, -1);
    repeat (3) @(negedge clk);
    chk("after_abort_byte", int'(rx_byte), 8'h81);
    chk("after_abort_valid", valid_cnt, 1);
    chk("after_abort_latency", done_ticks, EXP_LAT);

    // Stray start pulses mid-frame are ignored.
    clear_counts();
    send_frame(8'h55, 1'b1, 1'b0, 20, 60);
    repeat (3) @(negedge clk);
    chk("stray_start_byte", int'(rx_byte), 8'h55);
    chk("stray_start_valid", valid_cnt, 1);
    chk("stray_start_done", done_cnt, 1);
    chk("stray_start_latency", done_ticks, EXP_LAT);

    // Back-to-back frames: second start the cycle after the first rx_done.
    clear_counts();
    send_frame(8'h00, 1'b1, 1'b0, -1, -1);
    send_frame(8'hFF, 1'b1, 1'b0, -1, -1);
    repeat (3) @(negedge clk);
    chk("b2b_valid", valid_cnt, 2);
    chk("b2b_done", done_cnt, 2);
    chk("b2b_first", (got.size() > 0) ? got[0] : -1, 8'h00);
    chk("b2b_second", (got.size() > 1) ? got[1] : -1, 8'hFF);
    chk("b2b_second_latency", done_ticks, EXP_LAT);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
